// File: rtl/alu_pkg.sv
// Shared ALU definitions: op encodings, datapath width and the result-side state type.
package alu_pkg;

    localparam int DATA_W = 32;

    localparam logic [3:0] OP_MOV = 4'b0000;
    localparam logic [3:0] OP_NOT = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0011;
    localparam logic [3:0] OP_OR  = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b0101;
    localparam logic [3:0] OP_XOR = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_SWI = 4'b1000;
    localparam logic [3:0] OP_LI  = 4'b1001;
    localparam logic [3:0] OP_LUI = 4'b1010;
    localparam logic [3:0] OP_LWI = 4'b1011;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; every 4-bit op code is legal, unlisted codes pass A through.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] c
);

    always_comb begin
        c = a;
        case (op)
            OP_MOV: c = a;
            OP_NOT: c = ~a;
            OP_ADD: c = a + b;
            OP_SUB: c = a - b;
            OP_OR:  c = a | b;
            OP_AND: c = a & b;
            OP_XOR: c = a ^ b;
            OP_SLT: c = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_LI:  c = {a[DATA_W-1:16], b[15:0]};
            OP_LUI: c = {b[15:0], a[15:0]};
            OP_LWI: c = b;
            default: c = a;
        endcase
    end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; `last` records the most recent winner and moves only on advance.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic last_reg;

    // A lone requester always wins; on contention the side that did not win last time goes.
    always_comb begin
        grant    = 2'b00;
        grant[0] = valid[0] && (!valid[1] || last_reg);
        grant[1] = valid[1] && (!valid[0] || !last_reg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= 1'b1;
        end else if (advance) begin
            last_reg <= grant[1];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters with a one-deep registered result stage.
// Optional ALU_ARBITER_STATS_EN adds saturating grant and stall counters.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int DATA_W = alu_pkg::DATA_W,
    parameter int TAG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    input  logic [3:0]        req0_op,
    input  logic [TAG_W-1:0]  req0_tag,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    input  logic [3:0]        req1_op,
    input  logic [TAG_W-1:0]  req1_tag,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              res_src,
    output logic [TAG_W-1:0]  res_tag
`ifdef ALU_ARBITER_STATS_EN
    ,
    output logic [15:0]       gnt0_cnt,
    output logic [15:0]       gnt1_cnt,
    output logic [15:0]       stall_cnt
`endif
);

    out_state_e        state_reg;
    logic [DATA_W-1:0] a_reg;
    logic [DATA_W-1:0] b_reg;
    logic [3:0]        op_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic              src_reg;

    logic       accept;
    logic [1:0] grant;
    logic [1:0] hs;
    logic       hs_any;

    assign res_valid = (state_reg == ST_FULL);
    assign accept    = !res_valid || res_ready;

    rr_arb2 u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   ({req1_valid, req0_valid}),
        .advance (hs_any),
        .grant   (grant)
    );

    // Ready is held low throughout reset even though accept is high there.
    assign req0_ready = rst_n && accept && grant[0];
    assign req1_ready = rst_n && accept && grant[1];
    assign hs         = {req1_valid && req1_ready, req0_valid && req0_ready};
    assign hs_any     = |hs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_EMPTY;
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= OP_MOV;
            tag_reg   <= '0;
            src_reg   <= 1'b0;
        end else begin
            if (hs_any) begin
                a_reg   <= hs[1] ? req1_a   : req0_a;
                b_reg   <= hs[1] ? req1_b   : req0_b;
                op_reg  <= hs[1] ? req1_op  : req0_op;
                tag_reg <= hs[1] ? req1_tag : req0_tag;
                src_reg <= hs[1];
            end
            case (state_reg)
                ST_EMPTY: begin
                    if (hs_any) begin
                        state_reg <= ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (res_ready && !hs_any) begin
                        state_reg <= ST_EMPTY;
                    end
                end
                default: state_reg <= ST_EMPTY;
            endcase
        end
    end

    alu #(.DATA_W(DATA_W)) u_alu (
        .a  (a_reg),
        .b  (b_reg),
        .op (op_reg),
        .c  (res_data)
    );

    assign res_src = src_reg;
    assign res_tag = tag_reg;

`ifdef ALU_ARBITER_STATS_EN
    logic [15:0] gnt_cnt_reg [2];
    logic [15:0] stall_cnt_reg;

    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt_cnt
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                gnt_cnt_reg[gi] <= '0;
            end else if (hs[gi]) begin
                gnt_cnt_reg[gi] <= sat_inc16(gnt_cnt_reg[gi]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_reg <= '0;
        end else if (res_valid && !res_ready) begin
            stall_cnt_reg <= sat_inc16(stall_cnt_reg);
        end
    end

    assign gnt0_cnt  = gnt_cnt_reg[0];
    assign gnt1_cnt  = gnt_cnt_reg[1];
    assign stall_cnt = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed-vector bench for alu_arbiter with hand-computed expected results.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_op, req1_op;
    logic [3:0]  req0_tag, req1_tag;
    logic        res_valid, res_ready;
    logic [31:0] res_data;
    logic        res_src;
    logic [3:0]  res_tag;
`ifdef ALU_ARBITER_STATS_EN
    logic [15:0] gnt0_cnt, gnt1_cnt, stall_cnt;
`endif

    int n_vec = 0;
    int n_err = 0;

    alu_arbiter #(.DATA_W(32), .TAG_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_op    (req0_op),
        .req0_tag   (req0_tag),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_op    (req1_op),
        .req1_tag   (req1_tag),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_src    (res_src),
        .res_tag    (res_tag)
`ifdef ALU_ARBITER_STATS_EN
        ,
        .gnt0_cnt   (gnt0_cnt),
        .gnt1_cnt   (gnt1_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [3:0]  tbl_op  [13];
    logic [31:0] tbl_a   [13];
    logic [31:0] tbl_b   [13];
    logic [31:0] tbl_exp [13];

    initial begin
        tbl_op  = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1000, 4'b0001, 4'b0100,
                    4'b0101, 4'b0110, 4'b0011, 4'b0010, 4'b0111, 4'b0000};
        tbl_a   = '{32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678,
                    32'h12345678, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFF0000, 32'h00000000,
                    32'hFFFFFFFF, 32'h00000001, 32'hDEADBEEF};
        tbl_b   = '{32'h0000ABCD, 32'h0000ABCD, 32'h0000ABCD, 32'h0000ABCD, 32'h0000ABCD,
                    32'h0000ABCD, 32'h0F0F0000, 32'h0FF00FF0, 32'h0F0F0F0F, 32'h00000001,
                    32'h00000002, 32'hFFFFFFFF, 32'h00000000};
        tbl_exp = '{32'h1234ABCD, 32'hABCD5678, 32'h0000ABCD, 32'h12345678, 32'h12345678,
                    32'hEDCBA987, 32'hFFFFF0F0, 32'h00F000F0, 32'hF0F00F0F, 32'hFFFFFFFF,
                    32'h00000001, 32'h00000000, 32'hDEADBEEF};

        rst_n = 1'b0;
        req0_valid = 1'b1; req0_a = '0; req0_b = '0; req0_op = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0; req1_tag = '0;
        res_ready = 1'b1;

        // Reset state, with req0 valid to confirm ready stays low in reset.
        #3;
        check_vec("rst_res_valid", 32'(res_valid), 32'd0);
        check_vec("rst_res_data", res_data, 32'd0);
        check_vec("rst_res_src", 32'(res_src), 32'd0);
        check_vec("rst_res_tag", 32'(res_tag), 32'd0);
        check_vec("rst_req0_ready", 32'(req0_ready), 32'd0);
        step();
        step();
        req0_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // Single op: 5 + 3, tag 7.
        req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd3; req0_op = 4'b0010; req0_tag = 4'd7;
        #2;
        check_vec("single_req0_ready", 32'(req0_ready), 32'd1);
        check_vec("single_req1_ready", 32'(req1_ready), 32'd0);
        step();
        req0_valid = 1'b0; req0_a = 32'hBAD0BAD0;
        #1;
        check_vec("single_res_valid", 32'(res_valid), 32'd1);
        check_vec("single_res_data", res_data, 32'd8);
        check_vec("single_res_src", 32'(res_src), 32'd0);
        check_vec("single_res_tag", 32'(res_tag), 32'd7);
        step();
        check_vec("single_drain_valid", 32'(res_valid), 32'd0);

        // Contention: req0 won last, so req1 goes first and grants alternate from there.
        req0_valid = 1'b1; req0_a = 32'd10; req0_b = 32'd4; req0_op = 4'b0011; req0_tag = 4'd1;
        req1_valid = 1'b1; req1_a = 32'hFFFFFFFF; req1_b = 32'd1; req1_op = 4'b0111; req1_tag = 4'd2;
        #1;
        check_vec("cont_first_req1_ready", 32'(req1_ready), 32'd1);
        check_vec("cont_first_req0_ready", 32'(req0_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            check_vec($sformatf("cont%0d_src", i), 32'(res_src), (i % 2 == 0) ? 32'd1 : 32'd0);
            check_vec($sformatf("cont%0d_data", i), res_data, (i % 2 == 0) ? 32'd1 : 32'd6);
            check_vec($sformatf("cont%0d_tag", i), 32'(res_tag), (i % 2 == 0) ? 32'd2 : 32'd1);
            check_vec($sformatf("cont%0d_req0_ready", i), 32'(req0_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
        end

        // Backpressure: hold the src0 result for three cycles while req1 waits.
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_b = 32'd2; req1_op = 4'b0010; req1_tag = 4'd9;
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req1_a = 32'(k) + 32'h100;
            #2;
            check_vec($sformatf("hold%0d_req1_ready", k), 32'(req1_ready), 32'd0);
            check_vec($sformatf("hold%0d_valid", k), 32'(res_valid), 32'd1);
            check_vec($sformatf("hold%0d_data", k), res_data, 32'd6);
            check_vec($sformatf("hold%0d_src", k), 32'(res_src), 32'd0);
            step();
        end
        req1_a = 32'd7;
        res_ready = 1'b1;
        #1;
        check_vec("release_req1_ready", 32'(req1_ready), 32'd1);
        step();
        req1_valid = 1'b0; req1_a = 32'h0;
        #1;
        check_vec("release_data", res_data, 32'd9);
        check_vec("release_src", 32'(res_src), 32'd1);
        check_vec("release_tag", 32'(res_tag), 32'd9);

        // Back-to-back op table on requester 0.
        for (int i = 0; i < 13; i++) begin
            req0_valid = 1'b1; req0_a = tbl_a[i]; req0_b = tbl_b[i];
            req0_op = tbl_op[i]; req0_tag = 4'(i);
            step();
            check_vec($sformatf("op%b_a%h", tbl_op[i], tbl_a[i]), res_data, tbl_exp[i]);
        end
        req0_valid = 1'b0;
        step();
        check_vec("table_drain_valid", 32'(res_valid), 32'd0);

        // Asynchronous reset while holding a result.
        req0_valid = 1'b1; req0_a = 32'h55; req0_op = 4'b0000; req0_tag = 4'd3;
        step();
        req0_valid = 1'b0; res_ready = 1'b0;
        #1;
        check_vec("rsthold_valid_before", 32'(res_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("rsthold_valid_async", 32'(res_valid), 32'd0);
        check_vec("rsthold_data_async", res_data, 32'd0);
        #1;
        rst_n = 1'b1; res_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h11; req0_tag = 4'd4;
        req1_valid = 1'b1; req1_a = 32'h22; req1_op = 4'b0000; req1_tag = 4'd5;
        #1;
        check_vec("rsthold_req0_ready", 32'(req0_ready), 32'd1);
        check_vec("rsthold_req1_ready", 32'(req1_ready), 32'd0);
        step();
        check_vec("rsthold_first_src", 32'(res_src), 32'd0);
        check_vec("rsthold_first_tag", 32'(res_tag), 32'd4);
        step();
        check_vec("rsthold_second_src", 32'(res_src), 32'd1);
        check_vec("rsthold_second_data", res_data, 32'h22);
        req0_valid = 1'b0; req1_valid = 1'b0;
        step();

`ifdef ALU_ARBITER_STATS_EN
        // Fresh counters: three req0 and two req1 handshakes, then four stalled cycles.
        rst_n = 1'b0;
        #1;
        check_vec("stats_rst_gnt0", 32'(gnt0_cnt), 32'd0);
        rst_n = 1'b1;
        step();
        req0_valid = 1'b1;
        for (int i = 0; i < 3; i++) step();
        req0_valid = 1'b0; req1_valid = 1'b1;
        for (int i = 0; i < 2; i++) step();
        req1_valid = 1'b0; res_ready = 1'b0;
        for (int i = 0; i < 4; i++) step();
        res_ready = 1'b1;
        step();
        check_vec("stats_gnt0", 32'(gnt0_cnt), 32'd3);
        check_vec("stats_gnt1", 32'(gnt1_cnt), 32'd2);
        check_vec("stats_stall", 32'(stall_cnt), 32'd4);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
